// File: rtl/display_pkg.sv
// display_pkg: scan FSM states, seven-segment patterns (abcdefg) and BCD decode.
package display_pkg;
  typedef enum logic {BLANK, DRIVE} state_t;
  localparam logic [1:7] SEG_0 = 7'b1111110;
  localparam logic [1:7] SEG_1 = 7'b0110000;
  localparam logic [1:7] SEG_2 = 7'b1101101;
  localparam logic [1:7] SEG_3 = 7'b1111001;
  localparam logic [1:7] SEG_4 = 7'b0110011;
  localparam logic [1:7] SEG_5 = 7'b1011011;
  localparam logic [1:7] SEG_6 = 7'b1011111;
  localparam logic [1:7] SEG_7 = 7'b1110000;
  localparam logic [1:7] SEG_8 = 7'b1111111;
  localparam logic [1:7] SEG_9 = 7'b1111011;
  localparam logic [1:7] SEG_BLANK = 7'b0000000;
  function automatic logic [1:7] decode(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running slot counter with end-of-guard and end-of-slot strobes.
module scan_tick_gen #(
  parameter int TICK_DIV = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  output logic guard_done,
  output logic slot_done
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign guard_done = cnt == CW'(GUARD_CYCLES - 1);
  assign slot_done = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= slot_done ? '0 : cnt + 1'b1;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed seven-segment scanner with frame-boundary commit of loaded BCD frames.
// Define SCAN_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic load_ack,
  output logic [NUM_DIGITS-1:0] an,
  output logic [1:7] leds
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  state_t state;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] active, pending;
  logic pending_valid, guard_done, slot_done, wrap;
  logic [3:0] digit;
  logic [1:7] seg;
  scan_tick_gen #(.TICK_DIV(TICK_DIV), .GUARD_CYCLES(GUARD_CYCLES)) u_tick (
    .clk(clk),
    .rst(rst),
    .guard_done(guard_done),
    .slot_done(slot_done)
  );
  assign wrap = idx == IW'(NUM_DIGITS - 1);
  assign digit = active[4*int'(idx) +: 4];
`ifdef SCAN_LEADING_ZERO_BLANK_EN
  logic lz;
  always_comb begin
    lz = idx != '0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(idx) && active[4*j +: 4] != 4'd0) lz = 1'b0;
    seg = lz ? SEG_BLANK : decode(digit);
  end
`else
  assign seg = decode(digit);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      idx <= '0;
      active <= '0;
      pending <= '0;
      pending_valid <= 1'b0;
      an <= '0;
      leds <= SEG_BLANK;
      load_ack <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (load) begin
        pending <= bcd_in;
        pending_valid <= 1'b1;
      end
      if (state == BLANK && guard_done) begin
        state <= DRIVE;
        an <= NUM_DIGITS'(1) << idx;
        leds <= seg;
      end
      if (state == DRIVE && slot_done) begin
        state <= BLANK;
        an <= '0;
        leds <= SEG_BLANK;
        idx <= wrap ? '0 : idx + 1'b1;
        // Frame boundary: a load arriving this very cycle wins over the pending copy.
        if (wrap && (pending_valid || load)) begin
          active <= load ? bcd_in : pending;
          pending_valid <= 1'b0;
          load_ack <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: time-based reference model of scan timing and frame commits, directed plus random loads.
module tb_display_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic load_ack;
  logic [3:0] an;
  logic [1:7] leds;
  int checks = 0, errors = 0, t = 0;
  logic [15:0] act = 16'h0, pend = 16'h0;
  logic pv = 1'b0, ack_exp = 1'b0;
  logic [1:7] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  display_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(8), .GUARD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .load_ack(load_ack), .an(an), .leds(leds)
  );

  always #5 clk = ~clk;

  function automatic logic [1:7] exp_seg(input logic [15:0] f, input int k);
    logic [3:0] d;
    d = f[4*k +: 4];
`ifdef SCAN_LEADING_ZERO_BLANK_EN
    if (k > 0 && (f >> (4*k)) == 16'h0) return 7'b0;
`endif
    return d < 4'd10 ? pat[d] : 7'b0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  // Check the current cycle, then apply inputs and advance the model across one edge.
  task automatic step(input logic ld, input logic [15:0] d);
    int ph, dg;
    logic commit;
    ph = t % 8;
    dg = (t / 8) % 4;
    chk("an", {4'b0, an}, ph >= 2 ? 8'(1 << dg) : 8'h0);
    chk("leds", {1'b0, leds}, ph >= 2 ? {1'b0, exp_seg(act, dg)} : 8'h0);
    chk("load_ack", {7'b0, load_ack}, {7'b0, ack_exp});
    load = ld;
    bcd_in = d;
    commit = (t % 32 == 31) && (pv || ld);
    ack_exp = commit;
    if (commit) begin
      act = ld ? d : pend;
      pv = 1'b0;
    end else if (ld) begin
      pend = d;
      pv = 1'b1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  task automatic idle_to(input int p);
    while (t % 32 != p) step(1'b0, 16'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", {4'b0, an}, 8'h0);
    chk("rst_leds", {1'b0, leds}, 8'h0);
    chk("rst_ack", {7'b0, load_ack}, 8'h0);
    rst = 1'b0;
    idle(70);
    idle_to(8);
    step(1'b1, 16'h1234);
    idle(70);
    step(1'b1, 16'h00A0);
    idle(70);
    idle_to(3);
    step(1'b1, 16'h1111);
    idle(2);
    step(1'b1, 16'h2222);
    idle(70);
    idle_to(31);
    step(1'b1, 16'h5678);
    idle(40);
    step(1'b1, 16'h0070);
    idle(70);
    step(1'b1, 16'h9999);
    idle_to(12);
    rst = 1'b1;
    #1;
    chk("async_rst_an", {4'b0, an}, 8'h0);
    chk("async_rst_leds", {1'b0, leds}, 8'h0);
    chk("async_rst_ack", {7'b0, load_ack}, 8'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t = 0;
    act = 16'h0;
    pend = 16'h0;
    pv = 1'b0;
    ack_exp = 1'b0;
    idle(70);
    repeat (1500) step($urandom_range(0, 19) == 0, 16'($urandom));
    idle(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display sharing one BCD-to-segment decode path. Holds a committed frame of BCD digits, cycles through the digits one at a time with a guard interval between them, and drives one-hot digit enables plus the segment pattern `abcdefg`. New frames are loaded with a request/acknowledge handshake and committed only at frame boundaries, so a digit never shows a torn frame. Sits between the counter/arithmetic datapath producing BCD and the board display pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned; must be ≥1.
- `TICK_DIV`, 50000: clock cycles per digit slot; must be ≥2.
- `GUARD_CYCLES`, 500: cycles at the start of each slot with all digits off; 1 ≤ GUARD_CYCLES < TICK_DIV.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: frame load request, sampled each cycle.
- `bcd_in` in 4*NUM_DIGITS: frame data; digit k = `bcd_in[4k+3:4k]`, digit 0 rightmost.
- `load_ack` out 1: one-cycle pulse when a frame is committed to the display.
- `an` out NUM_DIGITS: active-high, one-hot digit enable; bit k drives digit k.
- `leds` out [1:7]: active-high segments, `leds[1]` = a … `leds[7]` = g.

## Operation
- Reset (async, takes effect immediately): `an`=0, `leds`=0, `load_ack`=0, state BLANK, digit index 0, slot counter 0, active frame 0, pending frame 0, pending_valid 0.
- FSM states:
  - BLANK: `an`=0, `leds`=0 for GUARD_CYCLES cycles, then DRIVE.
  - DRIVE: `an` = one-hot(index), `leds` = decode(active[index]) for TICK_DIV−GUARD_CYCLES cycles, then BLANK. Index increments and wraps NUM_DIGITS−1 → 0.
- Decode: 0–9 map to standard patterns, e.g. 0=1111110, 1=0110000, 4=0110011, 7=1110000, 8=1111111. Codes 10–15 map to 0000000 (blank, never X).
- Load handshake:
  - `load`=1 captures `bcd_in` into pending and sets pending_valid.
  - A repeat load before commit overwrites pending (last wins). No ack is issued for overwritten data.
- Commit: occurs on the DRIVE→BLANK transition where index wraps to 0 (the frame boundary), if pending_valid or `load` is high that cycle.
  - active ← (`load` ? `bcd_in` : pending); pending_valid ← 0; `load_ack`=1 on the next cycle.
  - `load` in the commit cycle itself is committed directly and acknowledged once.
- A reset mid-frame discards both the pending and active frames. No ack is issued.

## Timing
- All outputs are registered. Decode is registered on the BLANK→DRIVE transition.
- After reset release, `an` goes 0 for GUARD_CYCLES cycles; digit 0 is enabled from cycle GUARD_CYCLES.
- Slot period is TICK_DIV cycles; frame period is NUM_DIGITS×TICK_DIV cycles.
- Load-to-display worst case: one frame period + GUARD_CYCLES.
- Two enables are never asserted simultaneously, and there are never fewer than GUARD_CYCLES cycles of all-off between consecutive digits.

## Configuration
- `SCAN_LEADING_ZERO_BLANK_EN` defined: while displaying, any digit k>0 whose value and all higher digits' values are 0 shows 0000000. Its `an` bit still follows the normal scan timing. Digit 0 is never blanked.
- `SCAN_LEADING_ZERO_BLANK_EN` undefined: all digits decode normally, including leading zeros.

## Structure
- Shared package `display_pkg`:
  - FSM state enum (BLANK, DRIVE).
  - 7-bit segment pattern constants for 0–9 and blank.
  - Decode function.
- Sub-module `scan_tick_gen`: slot counter that emits `guard_done` and `slot_done` strobes from TICK_DIV/GUARD_CYCLES. Cleared by `rst`.

## Test plan
Bench parameters: NUM_DIGITS=4, TICK_DIV=8, GUARD_CYCLES=2.
- Reset and scan order:
  - Release `rst`: `an`=0000 for 2 cycles, then 0001 for 6 cycles, 0000 for 2, 0010 for 6, and so on to 1000, then wrap to 0001.
  - Assert `rst` mid-DRIVE: `an` and `leds` go 0 the same cycle, without waiting for a clock edge.
- Basic load:
  - Pulse `load` with `bcd_in`=16'h1234.
  - At the next frame boundary `load_ack` pulses once.
  - Digit 0 then shows 0110011, digit 1 1111001, digit 2 1101101, digit 3 0110000.
- Invalid code: `bcd_in`=16'h00A0 → digit 1 `leds`=0000000 while `an`=0010, with no X on any output.
- Overwrite: load 16'h1111, then 16'h2222 in the same frame → a single `load_ack`; all digits show 1101101.
- Load in the commit cycle: assert `load` (16'h5678) exactly on the wrap cycle → committed with no extra frame of delay; one ack; digit 0 shows 1111111.
- `SCAN_LEADING_ZERO_BLANK_EN` with 16'h0070:
  - Digits 3 and 2 show 0000000, digit 1 shows 1110000, digit 0 shows 1111110.
  - Without the macro, digits 3 and 2 show 1111110.
